// File: rtl/rv_pkg.sv
// Shared types and opcode constants for the multi-cycle core control sequencer.
package rv_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_JALR   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  // instruction[6:2] major opcodes
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // SYSTEM is deliberately absent: it halts without flagging illegal.
  function automatic logic opcode_legal(input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
      OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/write-back sequencing,
// PC and register-file strobes, illegal-opcode halt and retired-instruction count.
module core_sequencer
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  opcode,
  input  logic        rd_we_dec,
  input  logic        branch_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        halted,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  ctrl_state_t state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;
  pc_sel_t     pc_sel_c;
  wb_sel_t     wb_sel_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    halted    = 1'b0;
    pc_sel_c  = PC_PLUS4;
    wb_sel_c  = WB_ALU;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        if (imem_ack) state_d = S_DECODE;
      end

      S_DECODE: begin
        if (opcode == OPC_SYSTEM) begin
          state_d = S_HALT;
        end else if (!opcode_legal(opcode)) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM;
          OPC_BRANCH: begin
            pc_we    = 1'b1;
            pc_sel_c = branch_taken ? PC_TARGET : PC_PLUS4;
            state_d  = S_FETCH;
          end
          OPC_MISC_MEM: begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OPC_STORE);
        if (dmem_ack) begin
          if (opcode == OPC_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we   = rd_we_dec;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        if (opcode == OPC_LOAD) wb_sel_c = WB_MEM;
        else if (opcode == OPC_JAL || opcode == OPC_JALR) wb_sel_c = WB_PC4;
        if (opcode == OPC_JAL) pc_sel_c = PC_TARGET;
        else if (opcode == OPC_JALR) pc_sel_c = PC_JALR;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase

    // pc_we is never asserted in HALT, so the count freezes there.
    instret_d = instret_q + {31'd0, pc_we};
  end

  assign pc_sel  = pc_sel_c;
  assign wb_sel  = wb_sel_c;
  assign illegal = illegal_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: the driver queues the expected output
// vector for every cycle it drives; a negedge monitor pops and compares.
module tb_core_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                         ST_M = 3'd4, ST_WB = 3'd5, ST_H = 3'd6;
  localparam logic [4:0] LOAD = 5'b00000, FENCE = 5'b00011, ADDI = 5'b00100,
                         STORE = 5'b01000, LUI = 5'b01101, BR = 5'b11000,
                         JALR = 5'b11001, JAL = 5'b11011, SYS = 5'b11100,
                         BAD = 5'b11111;

  typedef struct packed {
    logic [2:0]  st;
    logic        imr, irw, dr, dw, pw;
    logic [1:0]  ps;
    logic        rw;
    logic [1:0]  ws;
    logic        ill, hlt;
    logic [31:0] ir;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  opcode;
  logic        rd_we_dec, branch_taken, imem_ack, dmem_ack;
  logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, illegal, halted;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] instret;
  logic [2:0]  state;

  obs_t        sb[$];
  obs_t        exp_v, act_v;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] n_exp;

  core_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .rd_we_dec(rd_we_dec),
    .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .illegal(illegal), .halted(halted), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      act_v = '{st: state, imr: imem_req, irw: ir_we, dr: dmem_req, dw: dmem_we,
                pw: pc_we, ps: pc_sel, rw: rf_we, ws: wb_sel, ill: illegal,
                hlt: halted, ir: instret};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL vec%0d t=%0t: got st=%0d imr=%b irw=%b dr=%b dw=%b pw=%b ps=%0d rw=%b ws=%0d ill=%b hlt=%b instret=%0d | need st=%0d imr=%b irw=%b dr=%b dw=%b pw=%b ps=%0d rw=%b ws=%0d ill=%b hlt=%b instret=%0d",
                 vectors, $time, act_v.st, act_v.imr, act_v.irw, act_v.dr, act_v.dw,
                 act_v.pw, act_v.ps, act_v.rw, act_v.ws, act_v.ill, act_v.hlt, act_v.ir,
                 exp_v.st, exp_v.imr, exp_v.irw, exp_v.dr, exp_v.dw, exp_v.pw,
                 exp_v.ps, exp_v.rw, exp_v.ws, exp_v.ill, exp_v.hlt, exp_v.ir);
      end
    end
  end

  task automatic cyc(input logic [4:0] op, input logic rdwe, input logic bt,
                     input logic ia, input logic da);
    @(posedge clk); #1;
    opcode = op; rd_we_dec = rdwe; branch_taken = bt; imem_ack = ia; dmem_ack = da;
  endtask

  task automatic ex(input logic [2:0] st, input logic imr, input logic irw,
                    input logic dr, input logic dw, input logic pw, input logic [1:0] ps,
                    input logic rw, input logic [1:0] ws, input logic ill, input logic hlt);
    obs_t e;
    e = '{st: st, imr: imr, irw: irw, dr: dr, dw: dw, pw: pw, ps: ps, rw: rw,
          ws: ws, ill: ill, hlt: hlt, ir: n_exp};
    sb.push_back(e);
  endtask

  // FETCH with zero-wait ack, then DECODE
  task automatic fd(input logic [4:0] op, input logic rdwe);
    cyc(op, rdwe, 0, 1, 0); ex(ST_F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(op, rdwe, 0, 0, 0); ex(ST_D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // four-cycle ALU-class instruction ending in its WB retire
  task automatic alu(input logic [4:0] op, input logic rdwe,
                     input logic [1:0] ps, input logic [1:0] ws);
    fd(op, rdwe);
    cyc(op, rdwe, 0, 0, 0); ex(ST_E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(op, rdwe, 0, 0, 0); ex(ST_WB, 0, 0, 0, 0, 1, ps, rdwe, ws, 0, 0);
    n_exp++;
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; rd_we_dec = 1'b0; branch_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; n_exp = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ex(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    alu(ADDI, 1, 2'd0, 2'd0);

    // load: one fetch wait, stray acks in DECODE/MEM, dmem_ack three cycles late
    cyc(LOAD, 1, 0, 0, 0); ex(ST_F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 1, 0); ex(ST_F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 0, 1); ex(ST_D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 0, 0); ex(ST_E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 1, 0); ex(ST_M, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 0, 0); ex(ST_M, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 0, 0); ex(ST_M, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 0, 1); ex(ST_M, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 0, 0); ex(ST_WB, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    n_exp++;

    // store retires out of MEM, rf_we stays low despite rd_we_dec
    fd(STORE, 1);
    cyc(STORE, 1, 0, 0, 0); ex(ST_E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(STORE, 1, 0, 0, 1); ex(ST_M, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    n_exp++;

    // branch taken / not taken, fence
    fd(BR, 1);
    cyc(BR, 1, 1, 0, 0); ex(ST_E, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    n_exp++;
    fd(BR, 1);
    cyc(BR, 1, 0, 0, 0); ex(ST_E, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    n_exp++;
    fd(FENCE, 1);
    cyc(FENCE, 1, 1, 0, 0); ex(ST_E, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    n_exp++;

    alu(JALR, 0, 2'd2, 2'd2);
    alu(JAL, 1, 2'd1, 2'd2);
    alu(LUI, 1, 2'd0, 2'd0);

    // SYSTEM halts cleanly; reset clears instret
    fd(SYS, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(SYS, 1, 1, 1, 1); ex(ST_H, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    cyc(SYS, 0, 0, 0, 0); rst_n = 1'b0; ex(ST_H, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_exp = '0;
    cyc(SYS, 0, 0, 0, 0); rst_n = 1'b1; ex(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // illegal opcode: absorbing HALT for 20 cycles, then one-cycle reset
    fd(BAD, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(BAD, 1, i[0], ~i[0], i[1]); ex(ST_H, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    end
    cyc(BAD, 0, 0, 0, 0); rst_n = 1'b0; ex(ST_H, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(BAD, 0, 0, 0, 0); rst_n = 1'b1; ex(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset while a load waits in MEM abandons it with no retire
    alu(ADDI, 1, 2'd0, 2'd0);
    fd(LOAD, 1);
    cyc(LOAD, 1, 0, 0, 0); ex(ST_E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 0, 0); ex(ST_M, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(LOAD, 1, 0, 0, 0); rst_n = 1'b0; ex(ST_M, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    n_exp = '0;
    cyc(LOAD, 1, 0, 0, 1); rst_n = 1'b1; ex(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(ADDI, 1, 0, 0, 0); ex(ST_F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked vectors, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
